// File: rtl/mips_multicycle_control_pkg.sv
// Shared state encodings, mux-select codes and decode constants for the multicycle MIPS control.
package mips_multicycle_control_pkg;

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAdr  = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StExecute = 4'd6,
    StAluWb   = 4'd7,
    StBranch  = 4'd8,
    StAddiEx  = 4'd9,
    StAddiWb  = 4'd10,
    StJump    = 4'd11,
    StError   = 4'd15
  } state_e;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_BRANCH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FUNCT_JR = 6'h08;

endpackage

// File: rtl/mips_multicycle_control.sv
// Main control FSM of the multicycle MIPS core: sequences datapath muxes and strobes per
// instruction, stalls on mem_ready and counts retired instructions.
module mips_multicycle_control
  import mips_multicycle_control_pkg::*;
#(
  parameter int unsigned COUNT_W         = 32,
  parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               PCEn,
  output logic               IorD,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               RegDst,
  output logic               MemtoReg,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ALUOp,
  output logic [1:0]         PCSource,
  output logic               illegal_op,
  output logic [3:0]         state,
  output logic [COUNT_W-1:0] instr_count
);

  state_e               state_q, state_d;
  logic [COUNT_W-1:0]   instr_count_q;
  logic                 count_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StFetch;
      instr_count_q <= '0;
    end else begin
      state_q <= state_d;
      if (count_en) instr_count_q <= instr_count_q + COUNT_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch:   if (mem_ready) state_d = StDecode;
      StDecode: begin
        case (opcode)
          OP_LW, OP_SW: state_d = StMemAdr;
          OP_RTYPE:     state_d = StExecute;
          OP_BEQ:       state_d = StBranch;
          OP_ADDI:      state_d = StAddiEx;
          OP_J:         state_d = StJump;
          default:      state_d = StError;
        endcase
      end
      StMemAdr:  state_d = (opcode == OP_LW) ? StMemRd : StMemWr;
      StMemRd:   if (mem_ready) state_d = StMemWb;
      StMemWr:   if (mem_ready) state_d = StFetch;
      StExecute: state_d = (funct == FUNCT_JR) ? StFetch : StAluWb;
      StAddiEx:  state_d = StAddiWb;
      StMemWb, StAluWb, StBranch, StAddiWb, StJump: state_d = StFetch;
      StError:   state_d = HALT_ON_ILLEGAL ? StError : StFetch;
      default:   state_d = StError;
    endcase
  end

  // Retirement is any return to FETCH except a FETCH stall or leaving ERROR.
  assign count_en = (state_d == StFetch) && (state_q != StFetch) && (state_q != StError);

  always_comb begin
    PCEn       = 1'b0;
    IorD       = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_B;
    ALUOp      = ALUOP_ADD;
    PCSource   = PCSRC_ALU;
    illegal_op = 1'b0;
    unique case (state_q)
      StFetch: begin
        ALUSrcB = SRCB_FOUR;
        IRWrite = mem_ready;
        PCEn    = mem_ready;
      end
      StDecode:  ALUSrcB = SRCB_BRANCH;
      StMemAdr: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      StMemRd:   IorD = 1'b1;
      StMemWb: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      StMemWr: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      StExecute: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOP_FUNCT;
        PCEn    = (funct == FUNCT_JR);
      end
      StAluWb: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      StBranch: begin
        ALUSrcA  = 1'b1;
        ALUOp    = ALUOP_SUB;
        PCSource = PCSRC_ALUOUT;
        PCEn     = zero;
      end
      StAddiEx: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      StAddiWb:  RegWrite = 1'b1;
      StJump: begin
        PCSource = PCSRC_JUMP;
        PCEn     = 1'b1;
      end
      default:   illegal_op = 1'b1;
    endcase
    if (rst) begin
      PCEn     = 1'b0;
      IRWrite  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
    end
  end

  assign state       = state_q;
  assign instr_count = instr_count_q;

endmodule
